// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - instruction/data request ports and backing-memory port of the arbiter
interface mem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_req;
  logic [WIDTH-1:0] i_addr;
  logic             i_ready;
  logic             i_rvalid;
  logic [WIDTH-1:0] i_rdata;

  logic             d_req;
  logic             d_we;
  logic [WIDTH-1:0] d_addr;
  logic [WIDTH-1:0] d_wdata;
  logic             d_ready;
  logic             d_rvalid;
  logic [WIDTH-1:0] d_rdata;

  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_done;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester (instruction/data) arbiter onto one backing memory
// Data side wins by default; starve_cnt bounds how long an instruction refill can wait.
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    starve_cnt, starve_nxt;
  logic [WIDTH-1:0] lat_addr, lat_wdata;
  logic             lat_we;
  logic [WIDTH-1:0] i_rdata_q, d_rdata_q;
  logic             grant_i, grant_d;
  logic             busy;

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.i_req)
          starve_nxt = '0;
        // Grants are masked during reset so ready stays low while rst is high.
        if (!rst && bus.d_req && (!bus.i_req || starve_cnt < LIMIT)) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
          if (bus.i_req && starve_cnt != LIMIT)
            starve_nxt = starve_cnt + CW'(1);
        end else if (!rst && bus.i_req) begin
          grant_i    = 1'b1;
          state_nxt  = BUSY_I;
          starve_nxt = '0;
        end
      end
      BUSY_I: if (bus.mem_done) state_nxt = RESP_I;
      BUSY_D: if (bus.mem_done) state_nxt = RESP_D;
      RESP_I: state_nxt = IDLE;
      RESP_D: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      if (grant_i) begin
        lat_addr  <= bus.i_addr;
        lat_wdata <= '0;
        lat_we    <= 1'b0;
      end else if (grant_d) begin
        lat_addr  <= bus.d_addr;
        lat_wdata <= bus.d_wdata;
        lat_we    <= bus.d_we;
      end
      if (state == BUSY_I && bus.mem_done)
        i_rdata_q <= bus.mem_rdata;
      // A completed write reports zero rather than whatever the memory left on mem_rdata.
      if (state == BUSY_D && bus.mem_done)
        d_rdata_q <= lat_we ? '0 : bus.mem_rdata;
    end
  end

  assign busy = (state == BUSY_I) || (state == BUSY_D);

  assign bus.i_ready   = grant_i;
  assign bus.d_ready   = grant_d;
  assign bus.i_rvalid  = (state == RESP_I);
  assign bus.d_rvalid  = (state == RESP_D);
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = busy;
  assign bus.mem_we    = (state == BUSY_D) && lat_we;
  assign bus.mem_addr  = busy ? lat_addr : '0;
  assign bus.mem_wdata = busy ? lat_wdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable memory model
module tb_mem_arbiter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.WIDTH(WIDTH)) bus ();
  mem_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  string       grants = "";
  int          i_ready_cycs[$];
  int          last_i_rvalid_cyc = -1;

  logic [31:0] mem_img [logic [31:0]];
  int          mem_lat = 2;
  bit          stray_done = 1'b0;
  int          en_cycles = 0;
  int          first_en_cyc = -1;
  int          en_len = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] dtab [6];
  int          t0;
  bit          seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual '%s' required '%s'", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: completes after mem_lat cycles of mem_en; optional stray mem_done when idle.
  initial begin
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en) begin
        if (en_cycles == 0) first_en_cyc = cyc;
        en_cycles++;
        if (en_cycles == mem_lat) begin
          bus.mem_done = 1'b1;
          en_len = en_cycles;
          if (bus.mem_we) begin
            mem_img[bus.mem_addr] = bus.mem_wdata;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_wdata;
            wr_cnt++;
            bus.mem_rdata = 32'hFFFF_FFFF;
          end else begin
            bus.mem_rdata = mem_img.exists(bus.mem_addr) ? mem_img[bus.mem_addr] : 32'hBAD0_0000;
          end
        end else begin
          bus.mem_done  = 1'b0;
          bus.mem_rdata = 32'h5A5A_5A5A;
        end
      end else begin
        en_cycles     = 0;
        bus.mem_done  = stray_done;
        bus.mem_rdata = 32'hC0FF_EE00;
      end
    end
  end

  // Monitor: logs grants and pops the scoreboard on every completion pulse.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.i_ready || bus.d_ready)
        check("ready_exclusive", {bus.i_ready, bus.d_ready}, (bus.i_ready ? 2'b10 : 2'b01));
      if (bus.i_ready) begin
        grants = {grants, "I"};
        i_ready_cycs.push_back(cyc);
      end
      if (bus.d_ready) grants = {grants, "D"};
      if (bus.i_rvalid) begin
        last_i_rvalid_cyc = cyc;
        if (i_exp.size() == 0) check("i_rvalid_unexpected", 1, 0);
        else check("i_rdata", bus.i_rdata, i_exp.pop_front());
      end
      if (bus.d_rvalid) begin
        if (d_exp.size() == 0) check("d_rvalid_unexpected", 1, 0);
        else check("d_rdata", bus.d_rdata, d_exp.pop_front());
      end
    end
  end

  task automatic do_i(input logic [31:0] addr, input logic [31:0] exp);
    bit got = 1'b0;
    i_exp.push_back(exp);
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = bus.i_ready;
    end
    if (!got) begin
      check("i_ready_timeout", 0, 1);
      void'(i_exp.pop_back());
    end
    @(posedge clk);
    #1 bus.i_req = 1'b0;
  endtask

  task automatic do_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp);
    bit got = 1'b0;
    d_exp.push_back(exp);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = bus.d_ready;
    end
    if (!got) begin
      check("d_ready_timeout", 0, 1);
      void'(d_exp.pop_back());
    end
    @(posedge clk);
    #1 bus.d_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((i_exp.size() != 0 || d_exp.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (i_exp.size() != 0 || d_exp.size() != 0) check("drain_timeout", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    mem_img[32'h100] = 32'h00A0_0513;
    mem_img[32'h104] = 32'h00B0_0593;
    mem_img[32'h108] = 32'h00C0_0613;
    mem_img[32'h300] = 32'hCAFE_F00D;
    dtab[0] = 32'h1111_1111; dtab[1] = 32'h2222_2222; dtab[2] = 32'h3333_3333;
    dtab[3] = 32'h4444_4444; dtab[4] = 32'h5555_5555; dtab[5] = 32'h6666_6666;
    for (int k = 0; k < 6; k++) mem_img[32'h200 + 32'(4 * k)] = dtab[k];

    // Reset state with a request already pending, then single I read with mem_done 2 cycles in.
    i_exp.push_back(32'h00A0_0513);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {bus.i_ready, bus.d_ready}, 0);
    check("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    check("rst_mem_ctl", {bus.mem_en, bus.mem_we}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_grant_after_rst", bus.i_ready, 1);
    t0 = cyc;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    drain();
    check("lat_first_mem_en", first_en_cyc, t0 + 1);
    check("lat_mem_en_len", en_len, 2);
    check("lat_i_rvalid", last_i_rvalid_cyc, t0 + 3);
    check("i_rdata_hold", bus.i_rdata, 32'h00A0_0513);

    // Simultaneous requests: data write first, then instruction.
    grants = "";
    fork
      do_d(1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h0);
      do_i(32'h104, 32'h00B0_0593);
    join
    drain();
    check_str("simul_grant_order", grants, "DI");
    check("write_count", wr_cnt, 1);
    check("write_addr", wr_addr, 32'h1000);
    check("write_data", wr_data, 32'hDEAD_BEEF);

    // Starvation: six held data reads against one instruction refill.
    mem_lat = 1;
    grants = "";
    fork
      for (int k = 0; k < 6; k++) do_d(1'b0, 32'h200 + 32'(4 * k), 32'h0, dtab[k]);
      do_i(32'h108, 32'h00C0_0613);
    join
    drain();
    check_str("starve_grant_order", grants, "DDDDIDD");

    // Back-to-back instruction reads completing in the first mem_en cycle.
    i_ready_cycs.delete();
    do_i(32'h100, 32'h00A0_0513);
    do_i(32'h104, 32'h00B0_0593);
    do_i(32'h108, 32'h00C0_0613);
    drain();
    check("b2b_grant_count", i_ready_cycs.size(), 3);
    if (i_ready_cycs.size() == 3) begin
      check("b2b_spacing_1", i_ready_cycs[1] - i_ready_cycs[0], 3);
      check("b2b_spacing_2", i_ready_cycs[2] - i_ready_cycs[1], 3);
    end

    // Stray mem_done while idle and during the response cycle.
    stray_done = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stray_idle_mem_en", bus.mem_en, 0);
    check("stray_i_rdata_hold", bus.i_rdata, 32'h00C0_0613);
    check("stray_d_rdata_hold", bus.d_rdata, 32'h6666_6666);
    @(posedge clk);
    #1;
    do_i(32'h100, 32'h00A0_0513);
    do_d(1'b0, 32'h300, 32'h0, 32'hCAFE_F00D);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("stray_resp_i_rdata", bus.i_rdata, 32'h00A0_0513);
    stray_done = 1'b0;

    // Reset in the middle of a data write; the write must never complete.
    mem_lat = 5;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'h1234_5678;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = bus.d_ready;
    end
    check("midrst_d_ready", seen, 1);
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_ctl", {bus.mem_en, bus.mem_we}, 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    check("midrst_mem_wdata", bus.mem_wdata, 0);
    check("midrst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    mem_lat = 1;
    i_exp.push_back(32'h00B0_0593);
    bus.i_req = 1'b1; bus.i_addr = 32'h104;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_next_grant", bus.i_ready, 1);
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    drain();
    repeat (8) @(posedge clk);
    #1;
    check("midrst_write_abandoned", wr_cnt, 1);
    check("scoreboard_empty", i_exp.size() + d_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, address/data width.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive D grants allowed while I waits.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 i_req  input  1  instruction-side refill request; held with i_addr until i_ready.
REQ-006 i_addr  input  WIDTH  instruction-side word address.
REQ-007 i_ready  output  1  instruction request accepted (one-cycle pulse).
REQ-008 i_rvalid  output  1  instruction read data valid (one-cycle pulse).
REQ-009 i_rdata  output  WIDTH  instruction read data.
REQ-010 d_req  input  1  data-side request; held with d_we, d_addr, d_wdata until d_ready.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_addr  input  WIDTH  data-side address.
REQ-013 d_wdata  input  WIDTH  data-side write data.
REQ-014 d_ready  output  1  data request accepted (one-cycle pulse).
REQ-015 d_rvalid  output  1  data completion (read data or write ack), one-cycle pulse.
REQ-016 d_rdata  output  WIDTH  data read data.
REQ-017 mem_en  output  1  backing-memory access active.
REQ-018 mem_we  output  1  backing-memory write enable.
REQ-019 mem_addr  output  WIDTH  backing-memory address.
REQ-020 mem_wdata  output  WIDTH  backing-memory write data.
REQ-021 mem_rdata  input  WIDTH  backing-memory read data, valid when mem_done=1.
REQ-022 mem_done  input  1  backing-memory access complete this cycle.

Function
REQ-023 FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-024 IDLE, grant rule: d_req=1 and (i_req=0 or starve_cnt<STARVE_LIMIT) -> grant D; else i_req=1 -> grant I; neither -> stay IDLE.
REQ-025 Grant cycle: the matching ready is asserted combinationally in IDLE; request fields are latched into internal registers; next state BUSY_I/BUSY_D.
REQ-026 i_ready and d_ready are never both 1; ready is 0 outside IDLE.
REQ-027 BUSY_x: mem_en=1; mem_addr/mem_wdata/mem_we driven from latched registers, stable throughout; mem_we=0 for I.
REQ-028 mem_done is ignored outside BUSY_x states.
REQ-029 BUSY_x with mem_done=1: capture mem_rdata (D write: capture 0) into x_rdata register; next state RESP_x.
REQ-030 RESP_x: x_rvalid=1 for exactly one cycle, mem_en=0; next state IDLE.
REQ-031 x_rdata holds its value until the next RESP_x capture.
REQ-032 Latency: ready at cycle T, mem_en from T+1, mem_done at T+k (k>=1), rvalid at T+k+1; next grant no earlier than T+k+2.
REQ-033 starve_cnt, width clog2(STARVE_LIMIT+1): +1 on D grant while i_req=1, saturating at STARVE_LIMIT; cleared on I grant, and in IDLE when i_req=0.
REQ-034 Requests arriving during BUSY/RESP wait; no request is dropped while its req is held.
REQ-035 Requester deasserting req before ready: no access issued.

Reset
REQ-036 rst=1 forces IDLE immediately; all outputs 0; starve_cnt=0; latched registers 0.
REQ-037 rst during BUSY/RESP: transaction abandoned, no rvalid pulse produced after reset release.
REQ-038 First grant possible in the first rising edge cycle after rst deasserts.

Verification
REQ-039 I read only: i_req=1, i_addr=0x100, mem_done 2 cycles after mem_en, mem_rdata=0x00A00513 -> i_ready T, mem_en T+1..T+2, i_rvalid T+3, i_rdata=0x00A00513.
REQ-040 Simultaneous i_req and d_req (d_we=1, d_addr=0x1000, d_wdata=0xDEADBEEF), starve_cnt=0 -> D granted first, mem_we=1, mem_wdata=0xDEADBEEF, d_rvalid with d_rdata=0; I granted next.
REQ-041 Starvation: d_req and i_req held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D...; starve_cnt reaches 4 then clears.
REQ-042 Reset mid-access: rst pulsed in BUSY_D before mem_done -> all outputs 0 immediately, no d_rvalid afterwards, next grant follows reset release.
REQ-043 Stray mem_done=1 in IDLE and RESP -> no state change, no rvalid, no rdata update.
REQ-044 Back-to-back I reads with mem_done same cycle as first mem_en -> 3-cycle spacing between consecutive i_ready pulses.
